ace_kbd_matrix: RTL

//  Converts MiSTer ps2_key events and joystick_0 into the Jupiter Ace 8x5 key matrix sampled by the ace core.

---
 rtl/ace_kbd_matrix.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ace_kbd_matrix.sv
// ace_kbd_matrix: maps PS/2 key events and joystick onto the Jupiter Ace 8x5 key matrix with a minimum key hold
module ace_kbd_matrix #(
    parameter int HOLD_CYCLES = 200000,
    parameter int RELQ_DEPTH  = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joya,
    input  logic [7:0]  kbd_row,
    output logic [4:0]  kbd_col
);
    localparam int PW = $clog2(RELQ_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef struct packed {
        logic       valid;
        logic       comp;
        logic [5:0] idx;
    } rel_t;

    logic        old_tog_q, old_tog_d;
    logic        ev_q, ev_d;
    logic [9:0]  ev_key_q, ev_key_d;
    logic [39:0] key_q, key_d;
    logic [2:0]  comp_q, comp_d;
    logic [17:0] timer_q, timer_d;
    logic [PW:0] rd_q, rd_d, wr_q, wr_d;
    rel_t        relq_q [RELQ_DEPTH];
    rel_t        relq_d [RELQ_DEPTH];
    rel_t        dec, head;
    logic        t_zero, q_empty, q_full, press, rel, drain, pop;
    logic [39:0] cells;
    logic [4:0]  col;
    logic        unused;

    // Key index is row*5+col; composites carry the non-SHIFT key and set comp
    function automatic rel_t decode(input logic [8:0] k);
        logic       v;
        logic       c;
        logic [5:0] i;
        v = 1'b1;
        c = 1'b0;
        i = '0;
        case (k)
            9'h012, 9'h059: i = 6'd0;
            9'h014, 9'h114: i = 6'd1;
            9'h01A: i = 6'd2;
            9'h022: i = 6'd3;
            9'h021: i = 6'd4;
            9'h01C: i = 6'd5;
            9'h01B: i = 6'd6;
            9'h023: i = 6'd7;
            9'h02B: i = 6'd8;
            9'h034: i = 6'd9;
            9'h015: i = 6'd10;
            9'h01D: i = 6'd11;
            9'h024: i = 6'd12;
            9'h02D: i = 6'd13;
            9'h02C: i = 6'd14;
            9'h016: i = 6'd15;
            9'h01E: i = 6'd16;
            9'h026: i = 6'd17;
            9'h025: i = 6'd18;
            9'h02E: i = 6'd19;
            9'h045: i = 6'd20;
            9'h046: i = 6'd21;
            9'h03E: i = 6'd22;
            9'h03D: i = 6'd23;
            9'h036: i = 6'd24;
            9'h04D: i = 6'd25;
            9'h044: i = 6'd26;
            9'h043: i = 6'd27;
            9'h03C: i = 6'd28;
            9'h035: i = 6'd29;
            9'h05A, 9'h15A: i = 6'd30;
            9'h04B: i = 6'd31;
            9'h042: i = 6'd32;
            9'h03B: i = 6'd33;
            9'h033: i = 6'd34;
            9'h029: i = 6'd35;
            9'h03A: i = 6'd36;
            9'h031: i = 6'd37;
            9'h032: i = 6'd38;
            9'h02A: i = 6'd39;
            9'h066: begin c = 1'b1; i = 6'd20; end
            9'h16B: begin c = 1'b1; i = 6'd19; end
            9'h172: begin c = 1'b1; i = 6'd24; end
            9'h175: begin c = 1'b1; i = 6'd23; end
            9'h174: begin c = 1'b1; i = 6'd22; end
            default: v = 1'b0;
        endcase
        return '{valid: v, comp: c, idx: i};
    endfunction

    function automatic logic [2:0] comp_inc(input logic [2:0] c);
        return (c == 3'd7) ? c : c + 3'd1;
    endfunction

    function automatic logic [2:0] comp_dec(input logic [2:0] c);
        return (c == 3'd0) ? c : c - 3'd1;
    endfunction

    assign dec     = decode(ev_key_q[8:0]);
    assign t_zero  = timer_q == '0;
    assign q_empty = rd_q == wr_q;
    assign q_full  = (rd_q[PW-1:0] == wr_q[PW-1:0]) && (rd_q[PW] != wr_q[PW]);
    assign press   = ev_q && dec.valid && ev_key_q[9];
    assign rel     = ev_q && dec.valid && !ev_key_q[9];
    assign drain   = t_zero && !q_empty;
    assign pop     = drain || (rel && q_full);
    assign head    = relq_q[rd_q[PW-1:0]];
    assign unused  = ^joya[15:5];

    always_comb begin
        old_tog_d = ps2_key[10];
        ev_d      = ps2_key[10] != old_tog_q;
        ev_key_d  = ps2_key[9:0];
        key_d     = key_q;
        comp_d    = comp_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        relq_d    = relq_q;
        timer_d   = t_zero ? '0 : timer_q - 18'd1;
        if (pop) begin
            relq_d[rd_q[PW-1:0]] = '0;
            rd_d = rd_q + PTR_ONE;
            if (head.valid) key_d[head.idx] = 1'b0;
            if (head.valid && head.comp) comp_d = comp_dec(comp_d);
        end
        if (press) begin
            // Cancelled composite entries still owe their SHIFT decrement
            for (int i = 0; i < RELQ_DEPTH; i++) begin
                if (relq_d[i].valid && relq_d[i].idx == dec.idx) begin
                    relq_d[i].valid = 1'b0;
                    if (relq_d[i].comp) comp_d = comp_dec(comp_d);
                end
            end
            key_d[dec.idx] = 1'b1;
            if (dec.comp) comp_d = comp_inc(comp_d);
            timer_d = 18'(HOLD_CYCLES - 1);
        end
        if (rel) begin
            if (t_zero && q_empty) begin
                key_d[dec.idx] = 1'b0;
                if (dec.comp) comp_d = comp_dec(comp_d);
            end else begin
                relq_d[wr_q[PW-1:0]] = dec;
                wr_d = wr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            old_tog_q <= ps2_key[10];
            ev_q      <= 1'b0;
            ev_key_q  <= '0;
            key_q     <= '0;
            comp_q    <= '0;
            timer_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            for (int i = 0; i < RELQ_DEPTH; i++) relq_q[i] <= '0;
        end else begin
            old_tog_q <= old_tog_d;
            ev_q      <= ev_d;
            ev_key_q  <= ev_key_d;
            key_q     <= key_d;
            comp_q    <= comp_d;
            timer_q   <= timer_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            relq_q    <= relq_d;
        end
    end

    // Joystick is ORed live: R->8, L->5, D->6, U->7, Fire->0
    always_comb begin
        cells     = key_q;
        cells[0]  = key_q[0] | (comp_q != 3'd0);
        cells[22] = key_q[22] | joya[0];
        cells[19] = key_q[19] | joya[1];
        cells[24] = key_q[24] | joya[2];
        cells[23] = key_q[23] | joya[3];
        cells[20] = key_q[20] | joya[4];
        col = '0;
        for (int r = 0; r < 8; r++) col = kbd_row[r] ? col : (col | cells[r*5 +: 5]);
    end

    assign kbd_col = ~col;
endmodule
